mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one data-memory/peripheral port (DataMem-style: rd, wr, addr, wdata, rdata, accessable) between two requesters. Requester I is the instruction-fetch/loader side; requester D is the core load/store side. Registered request/ack handshake, round-robin on conflict, per-transaction timeout with sticky bus-error. Sits between multicyc_core and DataMem in the unified-memory build of the multicycle top.

Parameters:
TIMEOUT, 16, max cycles a granted transaction waits for iMemAccessable before aborting (2..255)
ERR_RDATA, 32'h0000_0000, read data returned on a timed-out read

Ports:
iClk  input  1  system clock, rising edge
iRst_n  input  1  asynchronous active-low reset
iIReq  input  1  requester I read request, held until oIAck
iIAddr  input  32  requester I address
oIRdData  output  32  requester I read data, valid while oIAck=1
oIAck  output  1  one-cycle completion pulse to I
iDReq  input  1  requester D request, held until oDAck
iDWr  input  1  D: 1=write, 0=read
iDAddr  input  32  D address
iDWrData  input  32  D write data
oDRdData  output  32  D read data, valid while oDAck=1
oDAck  output  1  one-cycle completion pulse to D
oMemRd  output  1  memory read strobe
oMemWr  output  1  memory write strobe
oMemAddr  output  32  memory address
oMemWrData  output  32  memory write data
iMemRdData  input  32  memory read data
iMemAccessable  input  1  memory completes current access this cycle
oBusErr  output  1  sticky: a transaction timed out
oErrAddr  output  32  address of first timed-out transaction

Behaviour:
- Reset (async, iRst_n=0): state IDLE, all outputs 0, round-robin pointer = D-preferred, timeout counter 0. Reset mid-transaction aborts it silently; no ack is issued.
- States: IDLE, BUSY_I, BUSY_D.
- IDLE: eligible requests = iIReq/iDReq, excluding a requester whose ack is high this cycle. One eligible -> grant it. Both -> grant the one not granted last (first conflict after reset goes to D). At grant edge, register addr, wr flag, wdata; next state BUSY_x; counter cleared.
- BUSY_x: oMemAddr/oMemWrData from grant registers; oMemRd = !wr, oMemWr = wr (I is always read). Strobe held constant until completion.
- Completion: cycle with iMemAccessable=1 in BUSY_x. At that edge: capture iMemRdData into oxRdData (reads only; writes leave it unchanged), assert oxAck for exactly the next cycle, drop strobes, return to IDLE, pointer = x.
- Timeout: counter increments every BUSY cycle without accessable. When it equals TIMEOUT-1 and accessable still 0, the edge aborts: ack pulsed as normal, read data = ERR_RDATA, oBusErr set, oErrAddr loaded if oBusErr was 0. Sticky until reset.
- Latency with zero-wait memory: req seen in cycle 0 -> strobe cycle 1 -> ack cycle 2. Re-grant possible in the ack cycle for the other requester only; same requester earliest at ack+1.
- Requester dropping req mid-transaction: transaction still completes and acks. Address/data changes after grant are ignored.
- Never both strobes high; never both acks high in the same cycle.

Decomposition:
- Shared package: state encoding constants (IDLE/BUSY_I/BUSY_D), requester IDs, ERR_RDATA default.
- One natural sub-module: mem_port_timeout_ctr (clear, enable, hit output at TIMEOUT-1). Rest is flat.

Test Plan:
- I read 0x0000_0010, accessable tied 1, rdata 0x1234_5678 -> oMemRd cycle 1, oIAck cycle 2 with oIRdData=0x1234_5678.
- D write 0x4000_000C data 0xFF, accessable after 3 wait cycles -> oMemWr high 4 cycles, oDAck one cycle after accessable, oDRdData unchanged.
- I and D request together, both held for 3 transactions each -> grants D, I, D, I, D, I; no overlapping strobes or acks.
- D read with accessable never asserted, TIMEOUT=16 -> oDAck 16 cycles after strobe start, oDRdData=0, oBusErr=1, oErrAddr=D address; a later timeout leaves oErrAddr unchanged.
- iRst_n low for 1 cycle while BUSY_I -> all outputs 0 immediately, no oIAck, next request served normally.
- D drops iDReq in the cycle after grant -> access still completes, oDAck still pulses once.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 8;

    localparam logic [DATA_W-1:0] ERR_RDATA_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arbState_e;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } reqId_e;

    // Granted transaction, latched at the grant edge.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wrData;
        logic              wr;
    } memReq_t;

    // Round-robin pick: with both eligible, the one not granted last wins.
    function automatic reqId_e pickWinner(input logic eligI, input logic eligD,
                                          input reqId_e lastGrant);
        if (eligD && (!eligI || (lastGrant == REQ_I))) begin
            return REQ_D;
        end
        return REQ_I;
    endfunction

endpackage

// File: rtl/mem_port_timeout_ctr.sv
// Per-transaction wait counter; hitC flags the last allowed wait cycle.
module mem_port_timeout_ctr
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rstN,
    input  logic clear,
    input  logic enable,
    output logic hitC
);

    logic [CNT_W-1:0] count;

    // Count wait cycles; clear has priority over enable.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign hitC = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one DataMem-style port between fetch/loader (I) and load/store (D).
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned       TIMEOUT   = 16,
    parameter logic [DATA_W-1:0] ERR_RDATA = ERR_RDATA_DEF
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic              iIReq,
    input  logic [ADDR_W-1:0] iIAddr,
    output logic [DATA_W-1:0] oIRdData,
    output logic              oIAck,
    input  logic              iDReq,
    input  logic              iDWr,
    input  logic [ADDR_W-1:0] iDAddr,
    input  logic [DATA_W-1:0] iDWrData,
    output logic [DATA_W-1:0] oDRdData,
    output logic              oDAck,
    output logic              oMemRd,
    output logic              oMemWr,
    output logic [ADDR_W-1:0] oMemAddr,
    output logic [DATA_W-1:0] oMemWrData,
    input  logic [DATA_W-1:0] iMemRdData,
    input  logic              iMemAccessable,
    output logic              oBusErr,
    output logic [ADDR_W-1:0] oErrAddr
);

    arbState_e         state,     stateNext;
    reqId_e            lastGrant, lastGrantNext;
    memReq_t           grant,     grantNext;
    logic              memRd,     memRdNext;
    logic              memWr,     memWrNext;
    logic              iAck,      iAckNext;
    logic              dAck,      dAckNext;
    logic [DATA_W-1:0] iRdData,   iRdDataNext;
    logic [DATA_W-1:0] dRdData,   dRdDataNext;
    logic              busErr,    busErrNext;
    logic [ADDR_W-1:0] errAddr,   errAddrNext;

    logic              ctrClear;
    logic              ctrEnable;
    logic              toHit;
    logic              eligI;
    logic              eligD;
    logic              abortC;
    logic [DATA_W-1:0] rdVal;

    mem_port_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) uTimeoutCtr (
        .clk    (iClk),
        .rstN   (iRst_n),
        .clear  (ctrClear),
        .enable (ctrEnable),
        .hitC   (toHit)
    );

    // Next-state and next-output logic for the arbiter.
    always_comb begin
        stateNext     = state;
        lastGrantNext = lastGrant;
        grantNext     = grant;
        memRdNext     = memRd;
        memWrNext     = memWr;
        iAckNext      = 1'b0;
        dAckNext      = 1'b0;
        iRdDataNext   = iRdData;
        dRdDataNext   = dRdData;
        busErrNext    = busErr;
        errAddrNext   = errAddr;
        ctrClear      = 1'b0;
        ctrEnable     = 1'b0;
        rdVal         = iMemRdData;
        // A requester still seeing its ack must not be re-granted that cycle.
        eligI         = iIReq && !iAck;
        eligD         = iDReq && !dAck;
        abortC        = toHit && !iMemAccessable;

        case (state)
            IDLE: begin
                if (eligI || eligD) begin
                    ctrClear = 1'b1;
                    if (pickWinner(eligI, eligD, lastGrant) == REQ_D) begin
                        grantNext.addr   = iDAddr;
                        grantNext.wrData = iDWrData;
                        grantNext.wr     = iDWr;
                        memRdNext        = !iDWr;
                        memWrNext        = iDWr;
                        stateNext        = BUSY_D;
                    end else begin
                        grantNext.addr   = iIAddr;
                        grantNext.wrData = '0;
                        grantNext.wr     = 1'b0;
                        memRdNext        = 1'b1;
                        memWrNext        = 1'b0;
                        stateNext        = BUSY_I;
                    end
                end
            end

            BUSY_I, BUSY_D: begin
                if (iMemAccessable || toHit) begin
                    rdVal     = abortC ? ERR_RDATA : iMemRdData;
                    memRdNext = 1'b0;
                    memWrNext = 1'b0;
                    stateNext = IDLE;
                    if (state == BUSY_I) begin
                        iAckNext      = 1'b1;
                        iRdDataNext   = rdVal;
                        lastGrantNext = REQ_I;
                    end else begin
                        dAckNext      = 1'b1;
                        lastGrantNext = REQ_D;
                        if (!grant.wr) begin
                            dRdDataNext = rdVal;
                        end
                    end
                    if (abortC) begin
                        busErrNext = 1'b1;
                        if (!busErr) begin
                            errAddrNext = grant.addr;
                        end
                    end
                end else begin
                    ctrEnable = 1'b1;
                end
            end

            default: begin
                stateNext = IDLE;
                memRdNext = 1'b0;
                memWrNext = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction without ack.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state     <= IDLE;
            lastGrant <= REQ_I;
            grant     <= '0;
            memRd     <= 1'b0;
            memWr     <= 1'b0;
            iAck      <= 1'b0;
            dAck      <= 1'b0;
            iRdData   <= '0;
            dRdData   <= '0;
            busErr    <= 1'b0;
            errAddr   <= '0;
        end else begin
            state     <= stateNext;
            lastGrant <= lastGrantNext;
            grant     <= grantNext;
            memRd     <= memRdNext;
            memWr     <= memWrNext;
            iAck      <= iAckNext;
            dAck      <= dAckNext;
            iRdData   <= iRdDataNext;
            dRdData   <= dRdDataNext;
            busErr    <= busErrNext;
            errAddr   <= errAddrNext;
        end
    end

    assign oIRdData   = iRdData;
    assign oIAck      = iAck;
    assign oDRdData   = dRdData;
    assign oDAck      = dAck;
    assign oMemRd     = memRd;
    assign oMemWr     = memWr;
    assign oMemAddr   = grant.addr;
    assign oMemWrData = grant.wrData;
    assign oBusErr    = busErr;
    assign oErrAddr   = errAddr;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with hand-computed expectations.
module tb_mem_port_arbiter;

    logic        iClk;
    logic        iRst_n;
    logic        iIReq;
    logic [31:0] iIAddr;
    logic [31:0] oIRdData;
    logic        oIAck;
    logic        iDReq;
    logic        iDWr;
    logic [31:0] iDAddr;
    logic [31:0] iDWrData;
    logic [31:0] oDRdData;
    logic        oDAck;
    logic        oMemRd;
    logic        oMemWr;
    logic [31:0] oMemAddr;
    logic [31:0] oMemWrData;
    logic [31:0] iMemRdData;
    logic        iMemAccessable;
    logic        oBusErr;
    logic [31:0] oErrAddr;

    int vecCnt = 0;
    int errCnt = 0;

    mem_port_arbiter #(
        .TIMEOUT   (16),
        .ERR_RDATA (32'h0000_0000)
    ) dut (
        .iClk           (iClk),
        .iRst_n         (iRst_n),
        .iIReq          (iIReq),
        .iIAddr         (iIAddr),
        .oIRdData       (oIRdData),
        .oIAck          (oIAck),
        .iDReq          (iDReq),
        .iDWr           (iDWr),
        .iDAddr         (iDAddr),
        .iDWrData       (iDWrData),
        .oDRdData       (oDRdData),
        .oDAck          (oDAck),
        .oMemRd         (oMemRd),
        .oMemWr         (oMemWr),
        .oMemAddr       (oMemAddr),
        .oMemWrData     (oMemWrData),
        .iMemRdData     (iMemRdData),
        .iMemAccessable (iMemAccessable),
        .oBusErr        (oBusErr),
        .oErrAddr       (oErrAddr)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCnt++;
        if (obs !== exp) begin
            errCnt++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; checks and drives happen 1ns after the edge.
    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic doReset();
        iRst_n = 1'b0;
        tick();
        tick();
        iRst_n = 1'b1;
    endtask

    initial begin
        int waitN;
        logic expD;
        iRst_n = 1'b0; iIReq = 1'b0; iIAddr = '0; iDReq = 1'b0; iDWr = 1'b0;
        iDAddr = '0; iDWrData = '0; iMemRdData = '0; iMemAccessable = 1'b0;
        #2;
        doReset();

        // Reset state
        checkVal("rst_rd",     oMemRd, 0);
        checkVal("rst_wr",     oMemWr, 0);
        checkVal("rst_acks",   {oIAck, oDAck}, 0);
        checkVal("rst_buserr", oBusErr, 0);

        // I read, zero-wait memory
        iIReq = 1'b1; iIAddr = 32'h0000_0010; iMemAccessable = 1'b1; iMemRdData = 32'h1234_5678;
        checkVal("i_c0_rd", oMemRd, 0);
        tick();
        checkVal("i_c1_rd",   oMemRd, 1);
        checkVal("i_c1_addr", oMemAddr, 32'h0000_0010);
        checkVal("i_c1_ack",  oIAck, 0);
        tick();
        checkVal("i_c2_ack",  oIAck, 1);
        checkVal("i_c2_data", oIRdData, 32'h1234_5678);
        checkVal("i_c2_rd",   oMemRd, 0);
        iIReq = 1'b0;
        tick();
        checkVal("i_c3_ack", oIAck, 0);

        // D write with 3 wait cycles
        iDReq = 1'b1; iDWr = 1'b1; iDAddr = 32'h4000_000C; iDWrData = 32'h0000_00FF;
        iMemAccessable = 1'b0; iMemRdData = 32'hDEAD_BEEF;
        tick();
        checkVal("dw_c1_rd",    oMemRd, 0);
        checkVal("dw_c1_addr",  oMemAddr, 32'h4000_000C);
        checkVal("dw_c1_wdata", oMemWrData, 32'h0000_00FF);
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) tick();
            checkVal($sformatf("dw_c%0d_wr", c), oMemWr, 1);
            checkVal($sformatf("dw_c%0d_ack", c), oDAck, 0);
        end
        iMemAccessable = 1'b1;
        tick();
        checkVal("dw_ack",   oDAck, 1);
        checkVal("dw_rdata", oDRdData, 0);
        checkVal("dw_wr",    oMemWr, 0);
        iDReq = 1'b0; iDWr = 1'b0;
        tick();
        checkVal("dw_ack_off", oDAck, 0);

        // Round-robin under contention, fresh pointer
        iMemAccessable = 1'b0;
        doReset();
        iIReq = 1'b1; iIAddr = 32'h0000_0100;
        iDReq = 1'b1; iDAddr = 32'h0000_0200; iDWr = 1'b0;
        iMemAccessable = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            iMemRdData = 32'hA000_0000 + 32'(c);
            if ((c % 2) == 1) begin
                expD = (((c - 1) / 2) % 2) == 0;
                checkVal($sformatf("rr_c%0d_addr", c), oMemAddr, expD ? 32'h200 : 32'h100);
                checkVal($sformatf("rr_c%0d_strb", c), {oMemRd, oMemWr}, 2'b10);
                checkVal($sformatf("rr_c%0d_acks", c), {oIAck, oDAck}, 2'b00);
            end else begin
                expD = (((c - 2) / 2) % 2) == 0;
                checkVal($sformatf("rr_c%0d_acks", c), {oIAck, oDAck}, expD ? 2'b01 : 2'b10);
                checkVal($sformatf("rr_c%0d_data", c), expD ? oDRdData : oIRdData,
                         32'hA000_0000 + 32'(c - 1));
                if (c == 10) iDReq = 1'b0;
                if (c == 12) iIReq = 1'b0;
            end
        end

        // D read that never completes -> timeout
        iMemAccessable = 1'b0;
        iDReq = 1'b1; iDWr = 1'b0; iDAddr = 32'h5000_0004;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (c == 1 || c == 16) begin
                checkVal($sformatf("to_c%0d_rd", c), oMemRd, 1);
                checkVal($sformatf("to_c%0d_ack", c), oDAck, 0);
                checkVal($sformatf("to_c%0d_err", c), oBusErr, 0);
            end
        end
        tick();
        checkVal("to_ack",     oDAck, 1);
        checkVal("to_rdata",   oDRdData, 32'h0000_0000);
        checkVal("to_buserr",  oBusErr, 1);
        checkVal("to_erraddr", oErrAddr, 32'h5000_0004);
        iDReq = 1'b0;
        iIReq = 1'b1; iIAddr = 32'h6000_0000;
        waitN = 0;
        while (!oIAck && waitN < 40) begin
            tick();
            waitN++;
        end
        checkVal("to2_ack",     oIAck, 1);
        checkVal("to2_latency", waitN, 17);
        checkVal("to2_rdata",   oIRdData, 32'h0000_0000);
        checkVal("to2_erraddr", oErrAddr, 32'h5000_0004);
        checkVal("to2_buserr",  oBusErr, 1);
        iIReq = 1'b0;
        tick();

        // Reset while BUSY_I
        iIReq = 1'b1; iIAddr = 32'h0000_0070;
        tick();
        checkVal("rb_c1_rd", oMemRd, 1);
        iRst_n = 1'b0; iIReq = 1'b0;
        #1;
        checkVal("rb_rd",      oMemRd, 0);
        checkVal("rb_addr",    oMemAddr, 0);
        checkVal("rb_buserr",  oBusErr, 0);
        checkVal("rb_erraddr", oErrAddr, 0);
        checkVal("rb_idata",   oIRdData, 0);
        @(posedge iClk);
        #1;
        iRst_n = 1'b1;
        tick();
        checkVal("rb_noack", oIAck, 0);
        checkVal("rb_idle",  oMemRd, 0);
        iIReq = 1'b1; iIAddr = 32'h0000_0080; iMemAccessable = 1'b1; iMemRdData = 32'h0BAD_F00D;
        tick();
        checkVal("rb2_rd",   oMemRd, 1);
        checkVal("rb2_addr", oMemAddr, 32'h0000_0080);
        tick();
        checkVal("rb2_ack",  oIAck, 1);
        checkVal("rb2_data", oIRdData, 32'h0BAD_F00D);
        iIReq = 1'b0;
        tick();

        // D drops request right after grant; address change ignored
        iMemAccessable = 1'b0;
        iDReq = 1'b1; iDWr = 1'b0; iDAddr = 32'h0000_0090;
        tick();
        checkVal("dd_c1_rd", oMemRd, 1);
        iDReq = 1'b0; iDAddr = 32'h0000_0FFF;
        tick();
        checkVal("dd_c2_addr", oMemAddr, 32'h0000_0090);
        checkVal("dd_c2_ack",  oDAck, 0);
        iMemAccessable = 1'b1; iMemRdData = 32'h5555_AAAA;
        tick();
        checkVal("dd_c3_ack",  oDAck, 1);
        checkVal("dd_c3_data", oDRdData, 32'h5555_AAAA);
        tick();
        checkVal("dd_c4_ack", oDAck, 0);
        checkVal("dd_c4_rd",  oMemRd, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
    end

endmodule
